// File: rtl/bus_pkg.sv
// Shared types and defaults for the round-robin serial bus arbiter.
package bus_pkg;

  localparam int unsigned STATE_W = 3;

  localparam int unsigned DEF_NUM_MASTERS = 4;
  localparam int unsigned DEF_ADDR_WIDTH  = 4;
  localparam int unsigned DEF_TIMEOUT     = 255;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_GRANT    = 3'd1,
    ST_ADDR     = 3'd2,
    ST_WAIT_SLV = 3'd3,
    ST_CONNECT  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first requester at or after i_ptr, searching upward with wrap.
module rr_select
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  localparam int unsigned IDX_W = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_ptr,
  output logic [IDX_W-1:0]       o_idx,
  output logic                   o_valid
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] w_sum;

  // Walk offsets from farthest to nearest so the nearest requester is the last one written.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + SUM_W'(k);
      if (w_sum >= SUM_W'(NUM_MASTERS)) begin
        w_sum = w_sum - SUM_W'(NUM_MASTERS);
      end
      if (i_req[w_sum[IDX_W-1:0]]) begin
        o_idx   = w_sum[IDX_W-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin serial bus arbiter: grant, serial address capture, slave handshake.
// Optional slave watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_tx,
  output logic [NUM_MASTERS-1:0] m_rx,
  input  logic                   slv_ready,
  input  logic                   slv_responded,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic                   addr_rdy,
  output logic                   timeout,
  output logic [STATE_W-1:0]     state_o
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned BIT_W = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;

  if (NUM_MASTERS < 2 || ADDR_WIDTH < 1 || TIMEOUT < 1) begin : g_param_check
    $error("bus_arbiter_rr: illegal parameter value");
  end

  arb_state_e             r_state;
  logic [IDX_W-1:0]       r_ptr;
  logic [IDX_W-1:0]       r_idx;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic [ADDR_WIDTH-1:0]  r_shift;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic                   r_addr_rdy;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] r_m_rx;

  logic [IDX_W-1:0]       w_win;
  logic                   w_win_valid;
  logic [NUM_MASTERS-1:0] w_win_onehot;
  logic                   w_bit;
  logic [ADDR_WIDTH-1:0]  w_shift_next;
  logic [IDX_W-1:0]       w_ptr_next;

  rr_select #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_select (
    .i_req   (m_tx),
    .i_ptr   (r_ptr),
    .o_idx   (w_win),
    .o_valid (w_win_valid)
  );

  assign w_win_onehot = NUM_MASTERS'(1) << w_win;
  assign w_bit        = m_tx[r_idx];
  // MSB arrives first, so each new bit enters at the bottom and older bits move up.
  assign w_shift_next = ADDR_WIDTH'({r_shift, w_bit});
  assign w_ptr_next   = (r_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_idx + IDX_W'(1);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);
  logic [WDOG_W-1:0] r_wdog;
  logic              r_timeout;
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_addr_rdy <= 1'b0;
      r_grant    <= '0;
      r_m_rx     <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      r_wdog     <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_m_rx <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          r_grant <= '0;
          if (w_win_valid) begin
            r_idx   <= w_win;
            r_grant <= w_win_onehot;
            r_m_rx  <= w_win_onehot;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          r_bit_cnt <= '0;
          r_state   <= ST_ADDR;
        end
        ST_ADDR: begin
          r_shift <= w_shift_next;
          if (r_bit_cnt == BIT_W'(ADDR_WIDTH - 1)) begin
            r_addr     <= w_shift_next;
            r_addr_rdy <= 1'b1;
            r_state    <= ST_WAIT_SLV;
`ifdef BUS_ARB_TIMEOUT_EN
            r_wdog     <= '0;
`endif
          end else begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          end
        end
        ST_WAIT_SLV: begin
          if (slv_ready) begin
            r_addr_rdy <= 1'b0;
            r_state    <= ST_CONNECT;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          // Watchdog expiry loses to a same-cycle slv_ready.
          else if (r_wdog == WDOG_W'(TIMEOUT - 1)) begin
            r_timeout  <= 1'b1;
            r_addr_rdy <= 1'b0;
            r_grant    <= '0;
            r_ptr      <= w_ptr_next;
            r_state    <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
          end
`endif
        end
        ST_CONNECT: begin
          if (slv_responded) begin
            r_grant <= '0;
            r_ptr   <= w_ptr_next;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_grant    <= '0;
          r_addr_rdy <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_rx     = r_m_rx;
  assign grant    = r_grant;
  assign addr     = r_addr;
  assign addr_rdy = r_addr_rdy;
  assign state_o  = r_state;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr (4 masters, 4-bit address, TIMEOUT=8).
module tb_bus_arbiter_rr;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] m_tx;
  logic [3:0] m_rx;
  logic       slv_ready;
  logic       slv_responded;
  logic [3:0] grant;
  logic [3:0] addr;
  logic       addr_rdy;
  logic       timeout;
  logic [2:0] state_o;

  int n_vec = 0;
  int n_err = 0;

  int         q_grant[$];
  logic [3:0] q_addr[$];

  bus_arbiter_rr #(
    .NUM_MASTERS (4),
    .ADDR_WIDTH  (4),
    .TIMEOUT     (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .m_tx          (m_tx),
    .m_rx          (m_rx),
    .slv_ready     (slv_ready),
    .slv_responded (slv_responded),
    .grant         (grant),
    .addr          (addr),
    .addr_rdy      (addr_rdy),
    .timeout       (timeout),
    .state_o       (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // status: 0 completed, 1 timed out, 2 still waiting after the bound
  task automatic run_txn(input logic [3:0] req, input int exp_w, input logic [3:0] a,
                         input int ready_at, input bit poke, output int status);
    int         w;
    logic [1:0] wi;
    logic [3:0] oh;
    logic [3:0] ea;
    status = 2;
    q_grant.push_back(exp_w);
    q_addr.push_back(a);
    check_eq("idle_before_req", 32'(state_o), 0);
    m_tx = req;
    tick();
    w  = q_grant.pop_front();
    wi = 2'(w);
    oh = 4'b0001 << wi;
    check_eq("grant_state", 32'(state_o), 1);
    check_eq("grant_onehot", 32'(grant), 32'(oh));
    check_eq("ack_pulse", 32'(m_rx), 32'(oh));
    for (int b = 3; b >= 0; b--) begin
      tick();
      check_eq("addr_state", 32'(state_o), 2);
      check_eq("ack_low_in_addr", 32'(m_rx), 0);
      m_tx     = req;
      m_tx[wi] = a[2'(b)];
    end
    tick();
    m_tx = req;
    ea   = q_addr.pop_front();
    check_eq("addr_rdy_set", 32'(addr_rdy), 1);
    check_eq("addr_value", 32'(addr), 32'(ea));
    check_eq("grant_in_wait", 32'(grant), 32'(oh));
    for (int k = 1; k <= 12; k++) begin
      check_eq("wait_state", 32'(state_o), 3);
      check_eq("no_timeout_yet", 32'(timeout), 0);
      slv_ready     = (k == ready_at);
      slv_responded = poke;
      tick();
      slv_ready     = 1'b0;
      slv_responded = 1'b0;
      if (k == ready_at) begin
        check_eq("connect_state", 32'(state_o), 4);
        check_eq("addr_rdy_clr", 32'(addr_rdy), 0);
        check_eq("grant_in_connect", 32'(grant), 32'(oh));
        check_eq("no_timeout_on_ready", 32'(timeout), 0);
        status = 0;
        break;
      end else if (TO_EN && k == 8) begin
        check_eq("timeout_state", 32'(state_o), 0);
        check_eq("timeout_pulse", 32'(timeout), 1);
        check_eq("timeout_grant_clr", 32'(grant), 0);
        m_tx = 4'b0000;
        tick();
        check_eq("timeout_one_cycle", 32'(timeout), 0);
        status = 1;
        return;
      end
    end
    if (status == 2) return;
    slv_ready = poke;
    tick();
    slv_ready = 1'b0;
    check_eq("connect_hold", 32'(state_o), 4);
    check_eq("connect_grant_hold", 32'(grant), 32'(oh));
    slv_responded = 1'b1;
    tick();
    slv_responded = 1'b0;
    check_eq("done_idle", 32'(state_o), 0);
    check_eq("done_grant_clr", 32'(grant), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: got expired expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int st;
    rst           = 1'b1;
    m_tx          = 4'b0000;
    slv_ready     = 1'b0;
    slv_responded = 1'b0;
    tick();
    tick();
    check_eq("rst_state", 32'(state_o), 0);
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_m_rx", 32'(m_rx), 0);
    check_eq("rst_addr", 32'(addr), 0);
    check_eq("rst_addr_rdy", 32'(addr_rdy), 0);
    check_eq("rst_timeout", 32'(timeout), 0);
    rst = 1'b0;
    tick();

    // Single request from master 2, address 1011; ptr moves to 3.
    run_txn(4'b0100, 2, 4'b1011, 2, 1'b0, st);
    check_eq("single_status", 32'(st), 0);
    m_tx = 4'b0000;
    tick();

    // ptr=3 with masters 1 and 3 requesting: 3 first, then 1.
    run_txn(4'b1010, 3, 4'b0110, 1, 1'b0, st);
    run_txn(4'b1010, 1, 4'b1001, 1, 1'b0, st);
    m_tx = 4'b0000;
    tick();

    // Reset after two address bits (ptr is 2, so master 2 wins).
    m_tx = 4'b1111;
    tick();
    check_eq("mid_grant", 32'(grant), 32'(4'b0100));
    tick();
    m_tx[2] = 1'b1;
    tick();
    m_tx[2] = 1'b0;
    tick();
    rst  = 1'b1;
    m_tx = 4'b0000;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_state", 32'(state_o), 0);
    check_eq("mid_rst_grant", 32'(grant), 0);
    check_eq("mid_rst_addr", 32'(addr), 0);
    check_eq("mid_rst_addr_rdy", 32'(addr_rdy), 0);
    check_eq("mid_rst_m_rx", 32'(m_rx), 0);

    // All masters requesting continuously: 0,1,2,3 (proves ptr was reset to 0).
    run_txn(4'b1111, 0, 4'b0001, 1, 1'b0, st);
    run_txn(4'b1111, 1, 4'b1110, 3, 1'b1, st);
    run_txn(4'b1111, 2, 4'b0101, 2, 1'b0, st);
    run_txn(4'b1111, 3, 4'b1100, 1, 1'b1, st);
    m_tx = 4'b0000;
    tick();

    // Unresponsive slave on master 0.
    run_txn(4'b0001, 0, 4'b0111, 0, 1'b0, st);
    check_eq("timeout_status", 32'(st), TO_EN ? 1 : 2);
    if (st == 2) begin
      check_eq("stuck_in_wait", 32'(state_o), 3);
      rst  = 1'b1;
      m_tx = 4'b0000;
      tick();
      rst = 1'b0;
      check_eq("stuck_rst_state", 32'(state_o), 0);
    end

    // Expiry race: slv_ready in the 8th WAIT_SLV cycle wins; winner shows whether ptr advanced.
    run_txn(4'b0011, TO_EN ? 1 : 0, 4'b1010, 8, 1'b0, st);
    check_eq("race_status", 32'(st), 0);
    m_tx = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
